// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and helpers for the register-file write-port arbiter.
package regfile_write_arbiter_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // One-hot register mask used to build the pending-write scoreboard
    function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
        rd_onehot = NUM_REGS'(1) << rd;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Producer request channels and register-file write/scoreboard outputs of the arbiter.
interface regfile_write_arbiter_if #(
    parameter int unsigned XLEN = regfile_write_arbiter_pkg::XLEN
);
    import regfile_write_arbiter_pkg::*;

    logic                  pri_valid;
    logic                  pri_ready;
    logic [REG_ADDR_W-1:0] pri_rd;
    logic [XLEN-1:0]       pri_data;

    logic                  sec_valid;
    logic                  sec_ready;
    logic [REG_ADDR_W-1:0] sec_rd;
    logic [XLEN-1:0]       sec_data;

    logic                  wr_enable;
    logic [REG_ADDR_W-1:0] wr_address;
    logic [XLEN-1:0]       wr_data;
    logic [NUM_REGS-1:0]   pending_mask;
    logic                  idle;

    modport master (
        output pri_valid, pri_rd, pri_data, sec_valid, sec_rd, sec_data,
        input  pri_ready, sec_ready, wr_enable, wr_address, wr_data, pending_mask, idle
    );

    modport slave (
        input  pri_valid, pri_rd, pri_data, sec_valid, sec_rd, sec_data,
        output pri_ready, sec_ready, wr_enable, wr_address, wr_data, pending_mask, idle
    );

endinterface

// File: rtl/regfile_write_arbiter_arb_sync_fifo.sv
// Circular buffer for secondary writes; exposes per-entry valid/rd taps for the scoreboard.
module arb_sync_fifo
    import regfile_write_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic [REG_ADDR_W-1:0] push_rd,
    input  logic [DATA_W-1:0]     push_data,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [REG_ADDR_W-1:0] head_rd,
    output logic [DATA_W-1:0]     head_data,
    output logic [DEPTH-1:0]      entry_valid,
    output logic [REG_ADDR_W-1:0] entry_rd [DEPTH]
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [DEPTH-1:0]      valid_q;
    logic [DEPTH-1:0]      set_valid;
    logic [DEPTH-1:0]      clr_valid;
    logic                  do_push;
    logic                  do_pop;
    logic [REG_ADDR_W-1:0] rd_mem   [DEPTH];
    logic [DATA_W-1:0]     data_mem [DEPTH];

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        set_valid = '0;
        clr_valid = '0;
        if (do_push) set_valid = DEPTH'(1) << wr_ptr;
        if (do_pop)  clr_valid = DEPTH'(1) << rd_ptr;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            valid_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            valid_q <= (valid_q & ~clr_valid) | set_valid;
        end
    end

    // Payload storage needs no reset: every read is qualified by valid_q/empty
    always_ff @(posedge clock) begin
        if (do_push) begin
            rd_mem[wr_ptr]   <= push_rd;
            data_mem[wr_ptr] <= push_data;
        end
    end

    assign head_rd     = rd_mem[rd_ptr];
    assign head_data   = data_mem[rd_ptr];
    assign entry_valid = valid_q;
    assign entry_rd    = rd_mem;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register-file write port between pipeline writeback and a queued secondary path.
// Define REGFILE_ARB_STARVE_GUARD_EN to force a secondary grant after STARVE_LIMIT waiting cycles.
module regfile_write_arbiter #(
    parameter int unsigned XLEN  = regfile_write_arbiter_pkg::XLEN,
    parameter int unsigned DEPTH = 2
`ifdef REGFILE_ARB_STARVE_GUARD_EN
   ,parameter int unsigned STARVE_LIMIT = 4
`endif
) (
    input  logic                  clock,
    input  logic                  reset,
    regfile_write_arbiter_if.slave bus
);
    import regfile_write_arbiter_pkg::*;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  pri_ready_c;
    logic                  sec_ready_c;
    logic                  pri_grant;
    logic                  starve_force;
    logic [REG_ADDR_W-1:0] head_rd;
    logic [XLEN-1:0]       head_data;
    logic [DEPTH-1:0]      entry_valid;
    logic [REG_ADDR_W-1:0] entry_rd [DEPTH];
    logic                  wr_enable_q;
    logic [REG_ADDR_W-1:0] wr_address_q;
    logic [XLEN-1:0]       wr_data_q;
    logic [NUM_REGS-1:0]   pending;

`ifdef REGFILE_ARB_STARVE_GUARD_EN
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [STARVE_W-1:0] starve_cnt;

    assign starve_force = (starve_cnt == STARVE_W'(STARVE_LIMIT));

    // Counts cycles the FIFO head waits; saturates at the limit and clears on pop
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (fifo_pop || fifo_empty) begin
            starve_cnt <= '0;
        end else if (!starve_force) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
        end
    end
`else
    assign starve_force = 1'b0;
`endif

    // Grant: forced head pop, else primary, else head pop
    assign pri_ready_c = !reset && !(!fifo_empty && starve_force);
    assign sec_ready_c = !reset && !fifo_full;
    assign pri_grant   = bus.pri_valid && pri_ready_c;
    assign fifo_pop    = !reset && !fifo_empty && !pri_grant;
    assign fifo_push   = bus.sec_valid && sec_ready_c && (bus.sec_rd != REG_ZERO);

    arb_sync_fifo #(
        .DATA_W (XLEN),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .push        (fifo_push),
        .push_rd     (bus.sec_rd),
        .push_data   (bus.sec_data),
        .pop         (fifo_pop),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .head_rd     (head_rd),
        .head_data   (head_data),
        .entry_valid (entry_valid),
        .entry_rd    (entry_rd)
    );

    // Output stage: x0 writes complete their handshake but never raise wr_enable
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_enable_q  <= 1'b0;
            wr_address_q <= '0;
            wr_data_q    <= '0;
        end else if (pri_grant) begin
            wr_enable_q  <= (bus.pri_rd != REG_ZERO);
            wr_address_q <= bus.pri_rd;
            wr_data_q    <= bus.pri_data;
        end else if (fifo_pop) begin
            wr_enable_q  <= 1'b1;
            wr_address_q <= head_rd;
            wr_data_q    <= head_data;
        end else begin
            wr_enable_q  <= 1'b0;
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (entry_valid[i]) pending = pending | rd_onehot(entry_rd[i]);
        end
        if (wr_enable_q) pending = pending | rd_onehot(wr_address_q);
    end

    assign bus.pri_ready    = pri_ready_c;
    assign bus.sec_ready    = sec_ready_c;
    assign bus.wr_enable    = wr_enable_q;
    assign bus.wr_address   = wr_address_q;
    assign bus.wr_data      = wr_data_q;
    assign bus.pending_mask = pending;
    assign bus.idle         = fifo_empty && !wr_enable_q;

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between two producers.
  - Primary: the in-order pipeline writeback.
  - Secondary: late/long-latency producers such as the load unit or the debug module.
- The secondary path is buffered in a small FIFO.
- A `pending_mask` scoreboard lets decode stall on RAW hazards against queued writes.
- Sits between the writeback stage/LSU and the register file write inputs (`write_enable`, `rd_address`, `rd_data`).

Parameters:
- XLEN, 32, data width of written values.
- DEPTH, 2, secondary FIFO entries (power of two, >= 2).
- STARVE_LIMIT, 4, max cycles a non-empty FIFO head waits before a forced grant (only with guard enabled).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- pri_valid  in  1  primary write request.
- pri_ready  out  1  primary request accepted this cycle.
- pri_rd  in  5  primary destination register.
- pri_data  in  XLEN  primary write value.
- sec_valid  in  1  secondary write request.
- sec_ready  out  1  FIFO can accept this cycle.
- sec_rd  in  5  secondary destination register.
- sec_data  in  XLEN  secondary write value.
- wr_enable  out  1  to register file `write_enable`.
- wr_address  out  5  to register file `rd_address`.
- wr_data  out  XLEN  to register file `rd_data`.
- pending_mask  out  32  bit i = a write to xi is queued or in the output stage.
- idle  out  1  FIFO empty and `wr_enable` low.

Behaviour:
- Reset (async, `reset` = 1):
  - `wr_enable` = 0, `wr_address` = 0, `wr_data` = 0.
  - FIFO empty, starvation counter = 0.
  - `pending_mask` = 0, `idle` = 1.
  - `pri_ready` = 0 and `sec_ready` = 0 while reset is asserted.
  - Reset mid-operation discards all queued and staged writes; none reach the register file.
- Handshake: a transfer occurs on a rising edge with valid && ready. Requesters hold rd/data stable while valid && !ready.
- `sec_ready` = !fifo_full. No pass-through when full: a simultaneous pop does not free space the same cycle.
- Secondary writes always go through the FIFO. Minimum latency from accept to `wr_enable` = 2 cycles.
- Grant, evaluated every cycle, one winner:
  1. FIFO non-empty and starve_force → pop head; `pri_ready` = 0.
  2. Else `pri_valid` → primary wins; `pri_ready` = 1.
  3. Else FIFO non-empty → pop head.
  4. Else no grant.
- When `pri_valid` = 0, `pri_ready` = 1 (except under starve_force).
- Output stage: the winner's rd/data register into `wr_*` at the edge. `wr_enable` is high the cycle after the grant; the register file commits on the following edge. `wr_enable` is 0 when there is no grant.
- x0 filter: a granted write with rd = 0 completes its handshake and is dropped.
  - `wr_enable` stays 0.
  - Never sets `pending_mask`; rd = 0 entries are not pushed into the FIFO.
- `pending_mask` is combinational: the OR of one-hot(rd) over all valid FIFO entries plus the output stage when `wr_enable` = 1.
- Ordering: writes reach the register file in grant order. A primary write and a queued secondary write to the same rd are ordered by grant. The pipeline must stall on `pending_mask` to avoid WAW/RAW; the arbiter does not reorder.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and the head is not popped; saturates at STARVE_LIMIT.
  - starve_force = (count == STARVE_LIMIT).
  - Clears on any pop.
- Simultaneous push and pop on a non-empty FIFO: both occur, count unchanged.
- Push into an empty FIFO: the entry is not eligible for grant until the next cycle.

Optional Feature:
- Macro: `REGFILE_ARB_STARVE_GUARD_EN`.
- Defined: starvation counter and forced secondary grant as above.
- Undefined: strict primary priority; no counter logic; `pri_ready` tied to 1 outside reset. Secondary can starve indefinitely under continuous `pri_valid`.

Decomposition:
- Shared package/config constants: XLEN = 32, REG_ADDR_W = 5, NUM_REGS = 32, REG_ZERO = 5'd0.
- Sub-module: `arb_sync_fifo`.
  - Circular buffer with read/write pointers and count.
  - Outputs: full, empty, head, and per-entry valid/rd taps for `pending_mask`.
  - Same async-reset and clock scheme.

Test Plan:
- Reset: assert `reset` mid-stream with 2 FIFO entries queued → `wr_enable` = 0, `pending_mask` = 0, `idle` = 1; no further writes after deassert.
- Primary only: `pri_valid` with rd = 5, data = 0xDEADBEEF → next cycle `wr_enable` = 1, `wr_address` = 5, `wr_data` = 0xDEADBEEF, `pending_mask` = 0x20.
- Secondary queued behind primary: `pri_valid` held for 3 cycles (rd 1, 2, 3), sec rd = 7 pushed in cycle 0 → writes rd 1, 2, 3, then 7. `pending_mask` bit 7 set from cycle 1 until the rd 7 write retires.
- FIFO full: push two sec writes (rd 8, 9) while `pri_valid` is held → `sec_ready` = 0 on cycle 2; a third request stalls and is accepted only after the first pop.
- x0 drop: `pri_valid` rd = 0 data = 0x1234 → `pri_ready` = 1, `wr_enable` stays 0, `pending_mask` = 0.
- Starvation (guard defined, STARVE_LIMIT = 4): continuous `pri_valid`, one sec entry → sec granted in the 5th cycle after becoming head, `pri_ready` = 0 that cycle. Guard undefined → never granted while `pri_valid` = 1.
